// File: rtl/spi_arb.sv
// spi_arb: round-robin arbiter sharing one SPI master between two requesters.
// Optional WAIT timeout (err reporting) is built when SPI_ARB_TIMEOUT_EN is defined.
module spi_arb (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic [2:0]  ss0,
   input  logic [15:0] data0,
   input  logic        req1,
   input  logic [2:0]  ss1,
   input  logic [15:0] data1,
   output logic        done0,
   output logic        done1,
   output logic [7:0]  rdata,
   output logic        busy,
   output logic        gnt,
   output logic        err,
   output logic        wrt_SPI,
   output logic [15:0] SPI_data,
   output logic [2:0]  ss,
   input  logic        SPI_done,
   input  logic [7:0]  EEP_data
);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic        gnt_q, gnt_d;
   logic        last_q, last_d;
   logic [2:0]  ss_q, ss_d;
   logic [15:0] data_q, data_d;
   logic        busy_q, busy_d;
   logic        wrt_q, wrt_d;
   logic        done0_q, done0_d;
   logic        done1_q, done1_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        win;

`ifdef SPI_ARB_TIMEOUT_EN
   logic        err_q, err_d;
   logic [15:0] cnt_q, cnt_d;
`endif

   // Next-state and next-output computation for the arbitration FSM.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      ss_d    = ss_q;
      data_d  = data_q;
      busy_d  = busy_q;
      wrt_d   = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      rdata_d = rdata_q;
      win     = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      err_d   = err_q;
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // A tie goes to whoever was not served last.
               win     = (req0 && req1) ? ~last_q : req1;
               gnt_d   = win;
               last_d  = win;
               ss_d    = win ? ss1 : ss0;
               data_d  = win ? data1 : data0;
               busy_d  = 1'b1;
               wrt_d   = 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            state_d = WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: begin
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_d = cnt_q + 16'd1;
            if (!SPI_done && cnt_q == 16'hFFFF) begin
               rdata_d = 8'h00;
               err_d   = 1'b1;
               done0_d = ~gnt_q;
               done1_d = gnt_q;
               state_d = DONE;
            end
`endif
            if (SPI_done) begin
               rdata_d = EEP_data;
               done0_d = ~gnt_q;
               done1_d = gnt_q;
               state_d = DONE;
`ifdef SPI_ARB_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset leaves requester 1 as last served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         ss_q    <= 3'b000;
         data_q  <= 16'h0000;
         busy_q  <= 1'b0;
         wrt_q   <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         rdata_q <= 8'h00;
`ifdef SPI_ARB_TIMEOUT_EN
         err_q   <= 1'b0;
         cnt_q   <= 16'h0000;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         ss_q    <= ss_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         wrt_q   <= wrt_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         rdata_q <= rdata_d;
`ifdef SPI_ARB_TIMEOUT_EN
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign done0    = done0_q;
   assign done1    = done1_q;
   assign rdata    = rdata_q;
   assign busy     = busy_q;
   assign gnt      = gnt_q;
   assign wrt_SPI  = wrt_q;
   assign SPI_data = data_q;
   assign ss       = ss_q;

`ifdef SPI_ARB_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: scoreboard bench for spi_arb.
// Launch and completion expectations are queued as stimulus is driven.
module tb_spi_arb;

   logic        clk;
   logic        rst_n;
   logic        req0, req1;
   logic [2:0]  ss0, ss1;
   logic [15:0] data0, data1;
   logic        done0, done1;
   logic [7:0]  rdata;
   logic        busy, gnt, err, wrt_SPI;
   logic [15:0] SPI_data;
   logic [2:0]  ss;
   logic        SPI_done;
   logic [7:0]  EEP_data;

   spi_arb dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (req0),
      .ss0      (ss0),
      .data0    (data0),
      .req1     (req1),
      .ss1      (ss1),
      .data1    (data1),
      .done0    (done0),
      .done1    (done1),
      .rdata    (rdata),
      .busy     (busy),
      .gnt      (gnt),
      .err      (err),
      .wrt_SPI  (wrt_SPI),
      .SPI_data (SPI_data),
      .ss       (ss),
      .SPI_done (SPI_done),
      .EEP_data (EEP_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        g;
      logic [2:0]  s;
      logic [15:0] d;
   } launch_t;

   typedef struct packed {
      logic       idx;
      logic [7:0] rd;
      logic       er;
   } done_t;

   typedef struct {
      logic        r0, r1;
      logic [2:0]  s0, s1;
      logic [15:0] d0, d1;
      logic [7:0]  eep;
      int          dly;
      logic        g;
   } vec_t;

   launch_t exp_l[$];
   done_t   exp_d[$];
   launch_t ml;
   done_t   md;
   int      checks = 0;
   int      passes = 0;
   int      n_done0 = 0;
   int      n_done1 = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail(input string name);
      checks++;
      $display("FAIL %s: event seen, none expected", name);
   endtask

   // Monitor: pops expectations on each strobe and done pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (wrt_SPI) begin
            if (exp_l.size() == 0) fail("wrt_unexpected");
            else begin
               ml = exp_l.pop_front();
               chk("gnt", gnt, ml.g);
               chk("ss", ss, ml.s);
               chk("spi_data", SPI_data, ml.d);
               chk("busy_at_wrt", busy, 1);
            end
         end
         if (done0 || done1) begin
            if (done0) n_done0++;
            if (done1) n_done1++;
            if (exp_d.size() == 0) fail("done_unexpected");
            else begin
               md = exp_d.pop_front();
               chk("done_vec", {done1, done0}, md.idx ? 2'b10 : 2'b01);
               chk("rdata", rdata, md.rd);
               chk("err", err, md.er);
               chk("busy_at_done", busy, 1);
            end
         end
      end
   end

   task automatic chk_reset(input string name);
      chk(name, {wrt_SPI, done0, done1, busy, gnt, err, ss, SPI_data, rdata}, 0);
   endtask

   task automatic wait_wrt();
      int n;
      n = 0;
      while (!wrt_SPI && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("wrt_seen", wrt_SPI, 1);
   endtask

   // Slave side: answer a launch after dly cycles; dly 0 adds a LAUNCH-cycle glitch.
   task automatic serve(input int dly, input logic [7:0] eep,
                        input logic idx, input bit drop);
      wait_wrt();
      if (drop) begin
         req0 = 1'b0;
         req1 = 1'b0;
      end
      if (dly == 0) begin
         SPI_done = 1'b1;
         EEP_data = 8'hEE;
         @(negedge clk);
         SPI_done = 1'b0;
         chk("launch_done_ignored", {done0, done1, busy}, 3'b001);
         dly = 2;
      end
      repeat (dly) @(negedge clk);
      SPI_done = 1'b1;
      EEP_data = eep;
      exp_d.push_back('{idx, eep, 1'b0});
      @(negedge clk);
      SPI_done = 1'b0;
      chk("done_latency", idx ? done1 : done0, 1);
   endtask

   vec_t vt[8];
   int   d0s, d1s;
   int   n;

   initial begin
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      ss0 = 3'b000; ss1 = 3'b000;
      data0 = 16'h0; data1 = 16'h0;
      SPI_done = 1'b0; EEP_data = 8'h00;

      vt[0] = '{1, 1, 3'b001, 3'b100, 16'h1111, 16'hA001, 8'h01, 3, 1'b0};
      vt[1] = '{1, 1, 3'b010, 3'b100, 16'h2222, 16'hA002, 8'h02, 1, 1'b1};
      vt[2] = '{0, 1, 3'b011, 3'b100, 16'h3333, 16'hA003, 8'hF3, 0, 1'b1};
      vt[3] = '{0, 1, 3'b001, 3'b000, 16'h4444, 16'hFFFF, 8'h04, 5, 1'b1};
      vt[4] = '{1, 1, 3'b011, 3'b001, 16'h0001, 16'h8000, 8'hA5, 2, 1'b0};
      vt[5] = '{1, 0, 3'b000, 3'b011, 16'hFFFF, 16'h5555, 8'hFF, 0, 1'b0};
      vt[6] = '{1, 1, 3'b010, 3'b111, 16'h6666, 16'h7777, 8'h00, 4, 1'b1};
      vt[7] = '{1, 0, 3'b100, 3'b010, 16'h9999, 16'h0000, 8'h3C, 1, 1'b0};

      repeat (3) @(negedge clk);
      chk_reset("reset_vals");
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset("idle_vals");

      // Single request, with a req1 blip while busy.
      ss0 = 3'b001; data0 = 16'h13A5;
      ss1 = 3'b010; data1 = 16'hBEEF;
      exp_l.push_back('{1'b0, 3'b001, 16'h13A5});
      req0 = 1'b1;
      @(negedge clk);
      chk("wrt_latency", wrt_SPI, 1);
      req0 = 1'b0;
      @(negedge clk);
      chk("wrt_one_cycle", wrt_SPI, 0);
      req1 = 1'b1;
      @(negedge clk);
      req1 = 1'b0;
      repeat (8) @(negedge clk);
      SPI_done = 1'b1;
      EEP_data = 8'h5C;
      exp_d.push_back('{1'b0, 8'h5C, 1'b0});
      @(negedge clk);
      SPI_done = 1'b0;
      chk("single_done0", {done1, done0}, 2'b01);
      @(negedge clk);
      chk("single_after", {done1, done0, busy}, 3'b000);
      chk("rdata_hold", rdata, 8'h5C);
      repeat (5) @(negedge clk);
      chk("single_launch_q", exp_l.size(), 0);

      // Tie after reset.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ss0 = 3'b011; data0 = 16'h0F0F;
      ss1 = 3'b100; data1 = 16'hA000;
      exp_l.push_back('{1'b0, 3'b011, 16'h0F0F});
      exp_l.push_back('{1'b1, 3'b100, 16'hA000});
      req0 = 1'b1; req1 = 1'b1;
      serve(4, 8'h81, 1'b0, 1'b0);
      serve(2, 8'h82, 1'b1, 1'b1);
      repeat (6) @(negedge clk);
      chk("tie_launch_q", exp_l.size(), 0);

      // Sustained contention.
      ss0 = 3'b010; data0 = 16'h2222;
      ss1 = 3'b100; data1 = 16'hA5A5;
      d0s = n_done0; d1s = n_done1;
      for (int i = 0; i < 6; i++)
         exp_l.push_back('{i[0], i[0] ? 3'b100 : 3'b010,
                           i[0] ? 16'hA5A5 : 16'h2222});
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 6; i++)
         serve(3 + i, 8'h10 + 8'(i), i[0], i == 5);
      repeat (6) @(negedge clk);
      chk("rr_done0_count", n_done0 - d0s, 3);
      chk("rr_done1_count", n_done1 - d1s, 3);
      chk("rr_launch_q", exp_l.size(), 0);

      // Reset in the middle of WAIT.
      ss0 = 3'b001; data0 = 16'hDEAD;
      exp_l.push_back('{1'b0, 3'b001, 16'hDEAD});
      req0 = 1'b1;
      wait_wrt();
      req0 = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_before_rst", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset("midwait_rst_1");
      @(negedge clk);
      chk_reset("midwait_rst_2");
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      chk_reset("midwait_after");

      // Table: first entry is the post-reset tie.
      foreach (vt[i]) begin
         exp_l.push_back('{vt[i].g, vt[i].g ? vt[i].s1 : vt[i].s0,
                           vt[i].g ? vt[i].d1 : vt[i].d0});
         ss0 = vt[i].s0; ss1 = vt[i].s1;
         data0 = vt[i].d0; data1 = vt[i].d1;
         req0 = vt[i].r0; req1 = vt[i].r1;
         serve(vt[i].dly, vt[i].eep, vt[i].g, 1'b1);
      end
      repeat (6) @(negedge clk);
      chk("table_launch_q", exp_l.size(), 0);

`ifdef SPI_ARB_TIMEOUT_EN
      ss1 = 3'b100; data1 = 16'hC0DE;
      exp_l.push_back('{1'b1, 3'b100, 16'hC0DE});
      req1 = 1'b1;
      wait_wrt();
      req1 = 1'b0;
      exp_d.push_back('{1'b1, 8'h00, 1'b1});
      n = 0;
      while (!(done0 || done1) && n < 70000) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_cycles", n, 65537);
      ss0 = 3'b011; data0 = 16'h0123;
      exp_l.push_back('{1'b0, 3'b011, 16'h0123});
      req0 = 1'b1;
      serve(3, 8'h77, 1'b0, 1'b1);
      @(negedge clk);
      chk("err_cleared", err, 0);
`else
      ss0 = 3'b011; data0 = 16'h0123;
      exp_l.push_back('{1'b0, 3'b011, 16'h0123});
      req0 = 1'b1;
      wait_wrt();
      req0 = 1'b0;
      repeat (2000) @(negedge clk);
      chk("hang_busy", busy, 1);
      chk("hang_err", err, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
`endif

      repeat (4) @(negedge clk);
      chk("final_launch_q", exp_l.size(), 0);
      chk("final_done_q", exp_d.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
